// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore main controller for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back for addu/subu/or, ori,
// lw, sw, beq and j. All control outputs decode from the state register only;
// op and zero steer the next state and PCEn.
// Optional feature macro: ILLEGAL_TRAP_EN -- when defined, an unlisted opcode
// parks the controller in TRAP (illegal=1) until reset; otherwise it is a
// two-cycle NOP that returns to FETCH.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUop,
  output logic [1:0] PCSource,
  output logic       ExtOp,
  output logic       instr_done,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ORIEX  = 4'd9,
    ORIWB  = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } stateT;

  stateT curState, nextState;

  // Write enables and the done pulse before reset gating.
  logic pcWriteRaw, pcWriteCondRaw, memWriteRaw, irWriteRaw, regWriteRaw, doneRaw;

  // State register: reset always returns to FETCH, abandoning any instruction.
  always_ff @(posedge clk) begin
    if (reset) curState <= FETCH;
    else       curState <= nextState;
  end

  // Next-state logic: opcode dispatch in DECODE, lw/sw split in MEMADR.
  always_comb begin
    nextState = FETCH;
    case (curState)
      FETCH:  nextState = DECODE;
      DECODE: begin
        case (op)
          OP_RTYPE:      nextState = EXEC;
          OP_LW, OP_SW:  nextState = MEMADR;
          OP_BEQ:        nextState = BRANCH;
          OP_ORI:        nextState = ORIEX;
          OP_J:          nextState = JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:       nextState = TRAP;
`else
          default:       nextState = FETCH;
`endif
        endcase
      end
      MEMADR: nextState = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nextState = MEMWB;
      EXEC:   nextState = ALUWB;
      ORIEX:  nextState = ORIWB;
`ifdef ILLEGAL_TRAP_EN
      TRAP:   nextState = TRAP;
`endif
      default: nextState = FETCH;
    endcase
  end

  // Moore output decode: every control defaults to 0, each state raises its own.
  always_comb begin
    pcWriteRaw     = 1'b0;
    pcWriteCondRaw = 1'b0;
    memWriteRaw    = 1'b0;
    irWriteRaw     = 1'b0;
    regWriteRaw    = 1'b0;
    doneRaw        = 1'b0;
    IorD           = 1'b0;
    RegDst         = 1'b0;
    MemtoReg       = 1'b0;
    ALUSrcA        = 1'b0;
    ALUSrcB        = 2'b00;
    ALUop          = 3'b000;
    PCSource       = 2'b00;
    ExtOp          = 1'b0;
    case (curState)
      FETCH: begin
        irWriteRaw = 1'b1;
        ALUSrcB    = 2'b01;
        pcWriteRaw = 1'b1;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ExtOp   = 1'b1;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
      end
      MEMRD: begin
        IorD = 1'b1;
      end
      MEMWB: begin
        MemtoReg    = 1'b1;
        regWriteRaw = 1'b1;
        doneRaw     = 1'b1;
      end
      MEMWR: begin
        IorD        = 1'b1;
        memWriteRaw = 1'b1;
        doneRaw     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 3'b111;
      end
      ALUWB: begin
        RegDst      = 1'b1;
        regWriteRaw = 1'b1;
        doneRaw     = 1'b1;
      end
      BRANCH: begin
        ALUSrcA        = 1'b1;
        ALUop          = 3'b001;
        PCSource       = 2'b01;
        pcWriteCondRaw = 1'b1;
        doneRaw        = 1'b1;
      end
      ORIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUop   = 3'b010;
      end
      ORIWB: begin
        regWriteRaw = 1'b1;
        doneRaw     = 1'b1;
      end
      JUMP: begin
        PCSource   = 2'b10;
        pcWriteRaw = 1'b1;
        doneRaw    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Reset suppresses every write so an abandoned instruction cannot commit.
  assign PCWrite     = pcWriteRaw     & ~reset;
  assign PCWriteCond = pcWriteCondRaw & ~reset;
  assign MemWrite    = memWriteRaw    & ~reset;
  assign IRWrite     = irWriteRaw     & ~reset;
  assign RegWrite    = regWriteRaw    & ~reset;
  assign instr_done  = doneRaw        & ~reset;
  assign PCEn        = PCWrite | (PCWriteCond & zero);
  assign state       = curState;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (curState == TRAP) & ~reset;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven, hand-sequenced and randomized checks of
// the multi-cycle controller against a per-instruction state-sequence model.
module tb_multicycle_ctrl;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_ORIEX = 9,
                 S_ORIWB = 10, S_JUMP = 11, S_TRAP = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic zero = 1'b0;
  logic PCWrite, PCWriteCond, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg;
  logic RegWrite, ALUSrcA, ExtOp, instr_done, illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUop;
  logic [3:0] state;

  int testsRun = 0;
  int failures = 0;

  typedef struct packed {
    logic pcw, pcwc, pcen, iord, memw, irw, regdst, memtoreg, regw, srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic extop, done, ill;
  } ctrlT;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       zero;
    int         len;
    logic [19:0] seq;
    int nDone, nRegW, nMemW, nPCEn;
  } vecT;

  int expQ[$];
  int cntDone, cntRegW, cntMemW, cntPCEn;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .PCSource(PCSource), .ExtOp(ExtOp), .instr_done(instr_done), .state(state),
    .illegal(illegal)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Control word each state must present, written from the state descriptions.
  function automatic ctrlT ctrlFor(input int s, input logic z);
    ctrlT c;
    c = '0;
    case (s)
      S_FETCH:  begin c.irw = 1; c.srcb = 2'b01; c.pcw = 1; end
      S_DECODE: begin c.srcb = 2'b11; c.extop = 1; end
      S_MEMADR: begin c.srca = 1; c.srcb = 2'b10; c.extop = 1; end
      S_MEMRD:  begin c.iord = 1; end
      S_MEMWB:  begin c.memtoreg = 1; c.regw = 1; c.done = 1; end
      S_MEMWR:  begin c.iord = 1; c.memw = 1; c.done = 1; end
      S_EXEC:   begin c.srca = 1; c.aluop = 3'b111; end
      S_ALUWB:  begin c.regdst = 1; c.regw = 1; c.done = 1; end
      S_BRANCH: begin c.srca = 1; c.aluop = 3'b001; c.pcsrc = 2'b01; c.pcwc = 1; c.done = 1; end
      S_ORIEX:  begin c.srca = 1; c.srcb = 2'b10; c.aluop = 3'b010; end
      S_ORIWB:  begin c.regw = 1; c.done = 1; end
      S_JUMP:   begin c.pcsrc = 2'b10; c.pcw = 1; c.done = 1; end
      S_TRAP:   begin c.ill = 1; end
      default:  c = '0;
    endcase
    c.pcen = c.pcw | (c.pcwc & z);
    return c;
  endfunction

  // Same word while reset is held: all writes, done and illegal suppressed.
  function automatic ctrlT gateReset(input ctrlT cIn);
    ctrlT c;
    c = cIn;
    c.pcw = 0; c.pcwc = 0; c.pcen = 0; c.memw = 0; c.irw = 0; c.regw = 0;
    c.done = 0; c.ill = 0;
    return c;
  endfunction

  function automatic ctrlT sampleDut();
    ctrlT c;
    c = {PCWrite, PCWriteCond, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
         RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, ExtOp, instr_done, illegal};
    return c;
  endfunction

  function automatic bit isLegal(input logic [5:0] o);
    return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
           (o == 6'b000100) || (o == 6'b001101) || (o == 6'b000010);
  endfunction

  // Reference model: expand one instruction into the states it visits.
  function automatic void buildSeq(input logic [5:0] o);
    expQ.delete();
    expQ.push_back(S_FETCH);
    expQ.push_back(S_DECODE);
    case (o)
      6'b100011: begin expQ.push_back(S_MEMADR); expQ.push_back(S_MEMRD); expQ.push_back(S_MEMWB); end
      6'b101011: begin expQ.push_back(S_MEMADR); expQ.push_back(S_MEMWR); end
      6'b000000: begin expQ.push_back(S_EXEC); expQ.push_back(S_ALUWB); end
      6'b000100: expQ.push_back(S_BRANCH);
      6'b001101: begin expQ.push_back(S_ORIEX); expQ.push_back(S_ORIWB); end
      6'b000010: expQ.push_back(S_JUMP);
      default: begin
`ifdef ILLEGAL_TRAP_EN
        expQ.push_back(S_TRAP);
`endif
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive op/zero, then walk expQ one cycle per entry checking state and controls.
  // Entered and left at negedge+1; leaves the DUT in the state after expQ.
  task automatic applyStimulus(input string nm, input logic [5:0] o, input logic z);
    op = o;
    zero = z;
    cntDone = 0; cntRegW = 0; cntMemW = 0; cntPCEn = 0;
    #1;
    for (int k = 0; k < expQ.size(); k++) begin
      checkOutput($sformatf("%s state c%0d", nm, k), 32'(state), 32'(expQ[k]));
      checkOutput($sformatf("%s ctrl c%0d", nm, k), 32'(sampleDut()), 32'(ctrlFor(expQ[k], z)));
      cntDone += int'(instr_done);
      cntRegW += int'(RegWrite);
      cntMemW += int'(MemWrite);
      cntPCEn += int'(PCEn);
      @(negedge clk);
      #1;
    end
  endtask

  vecT vecs[8];

  initial begin
    vecs[0] = '{"ori",    6'b001101, 1'b0, 4, 20'h0A910, 1, 1, 0, 1};
    vecs[1] = '{"lw",     6'b100011, 1'b0, 5, 20'h43210, 1, 1, 0, 1};
    vecs[2] = '{"sw",     6'b101011, 1'b1, 4, 20'h05210, 1, 0, 1, 1};
    vecs[3] = '{"beqT",   6'b000100, 1'b1, 3, 20'h00810, 1, 0, 0, 2};
    vecs[4] = '{"beqNT",  6'b000100, 1'b0, 3, 20'h00810, 1, 0, 0, 1};
    vecs[5] = '{"j",      6'b000010, 1'b0, 3, 20'h00B10, 1, 0, 0, 2};
    vecs[6] = '{"rtype",  6'b000000, 1'b0, 4, 20'h07610, 1, 1, 0, 1};
`ifdef ILLEGAL_TRAP_EN
    vecs[7] = '{"nopChk", 6'b001101, 1'b1, 4, 20'h0A910, 1, 1, 0, 1};
`else
    vecs[7] = '{"illNop", 6'b111111, 1'b0, 2, 20'h00010, 0, 0, 0, 1};
`endif

    // Reset held three cycles: FETCH with every write gated off.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset state", 32'(state), 32'(S_FETCH));
    checkOutput("reset ctrl", 32'(sampleDut()), 32'(gateReset(ctrlFor(S_FETCH, 1'b0))));
    reset = 1'b0;

    // Table-driven vectors: state trace from the table, pulse counts compared.
    for (int v = 0; v < 8; v++) begin
      logic [19:0] s;
      s = vecs[v].seq;
      expQ.delete();
      for (int k = 0; k < vecs[v].len; k++) expQ.push_back(int'(s[4*k +: 4]));
      applyStimulus(vecs[v].name, vecs[v].op, vecs[v].zero);
      checkOutput({vecs[v].name, " doneCount"}, 32'(cntDone), 32'(vecs[v].nDone));
      checkOutput({vecs[v].name, " regWCount"}, 32'(cntRegW), 32'(vecs[v].nRegW));
      checkOutput({vecs[v].name, " memWCount"}, 32'(cntMemW), 32'(vecs[v].nMemW));
      checkOutput({vecs[v].name, " pcEnCount"}, 32'(cntPCEn), 32'(vecs[v].nPCEn));
      checkOutput({vecs[v].name, " backToFetch"}, 32'(state), 32'(S_FETCH));
    end

    // Reset asserted in MEMRD of lw: abandoned, no register write.
    expQ.delete();
    expQ.push_back(S_FETCH); expQ.push_back(S_DECODE); expQ.push_back(S_MEMADR);
    applyStimulus("lwAbort", 6'b100011, 1'b0);
    checkOutput("lwAbort inMemRd", 32'(state), 32'(S_MEMRD));
    reset = 1'b1;
    #1;
    checkOutput("lwAbort regWGated", 32'(RegWrite), 32'(0));
    @(negedge clk);
    #1;
    checkOutput("lwAbort fetch", 32'(state), 32'(S_FETCH));
    checkOutput("lwAbort regWHeld", 32'(RegWrite), 32'(0));
    checkOutput("lwAbort regWTotal", 32'(cntRegW), 32'(0));
    reset = 1'b0;
    buildSeq(6'b001101);
    applyStimulus("afterAbort", 6'b001101, 1'b0);

`ifdef ILLEGAL_TRAP_EN
    // Illegal opcode parks in TRAP with illegal=1 until reset.
    buildSeq(6'b111111);
    for (int k = 0; k < 9; k++) expQ.push_back(S_TRAP);
    applyStimulus("trap", 6'b111111, 1'b0);
    checkOutput("trap holds", 32'(state), 32'(S_TRAP));
    checkOutput("trap doneCount", 32'(cntDone), 32'(0));
    reset = 1'b1;
    #1;
    checkOutput("trap illegalCleared", 32'(illegal), 32'(0));
    @(negedge clk);
    #1;
    checkOutput("trap exit", 32'(state), 32'(S_FETCH));
    reset = 1'b0;
`endif

    // Randomized instruction stream against the sequence model.
    for (int n = 0; n < 60; n++) begin
      logic [5:0] o;
      logic z;
      int r;
      r = int'($urandom_range(0, 7));
      z = 1'($urandom_range(0, 1));
      case (r)
        0: o = 6'b000000;
        1: o = 6'b100011;
        2: o = 6'b101011;
        3: o = 6'b000100;
        4: o = 6'b001101;
        5: o = 6'b000010;
        default: begin
          o = 6'b111111;
          for (int t = 0; t < 16; t++) begin
            logic [5:0] cand;
            cand = 6'($urandom);
            if (!isLegal(cand)) begin o = cand; break; end
          end
`ifdef ILLEGAL_TRAP_EN
          o = 6'b001101;
`endif
        end
      endcase
      buildSeq(o);
      applyStimulus($sformatf("rnd%0d op%b", n, o), o, z);
      checkOutput($sformatf("rnd%0d doneCount", n), 32'(cntDone), 32'(isLegal(o) ? 1 : 0));
      checkOutput($sformatf("rnd%0d pcEnCount", n), 32'(cntPCEn),
                  32'(1 + ((o == 6'b000010 || (o == 6'b000100 && z)) ? 1 : 0)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle MIPS main controller: a Moore state machine that sequences the shared datapath (single memory, one ALU, instruction register, register file, PC) through fetch, decode, execute, memory and write-back steps. It replaces the single-cycle combinational main decoder for the subset R-type (addu/subu/or), ori, lw, sw, beq and j. It sits beside the datapath, takes the IR opcode and the ALU zero flag, and drives every datapath enable and mux select.

## Interface
- No parameters.
- `clk`  in  1  system clock, all state changes on rising edge
- `reset`  in  1  synchronous, active-high; forces state to FETCH
- `op`  in  6  opcode field IR[31:26], valid from DECODE onward
- `zero`  in  1  ALU zero flag, sampled in BRANCH
- `PCWrite`  out  1  unconditional PC load
- `PCWriteCond`  out  1  PC load if `zero` (beq)
- `PCEn`  out  1  `PCWrite | (PCWriteCond & zero)`, the actual PC enable
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  load instruction register
- `RegDst`  out  1  write register: 0 = rt, 1 = rd
- `MemtoReg`  out  1  write data: 0 = ALUOut, 1 = MDR
- `RegWrite`  out  1  register file write
- `ALUSrcA`  out  1  0 = PC, 1 = register A
- `ALUSrcB`  out  2  00 = B, 01 = const 4, 10 = ext(imm), 11 = ext(imm)<<2
- `ALUop`  out  3  000 add, 001 sub, 010 or, 111 use funct
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `ExtOp`  out  1  1 = sign-extend imm, 0 = zero-extend
- `instr_done`  out  1  one-cycle pulse in the last cycle of each instruction
- `state`  out  4  current state code, for debug
- `illegal`  out  1  see Configuration

## Operation
- States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ORIEX 9, ORIWB 10, JUMP 11, TRAP 12.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUop=000, PCSource=00, PCWrite=1 → DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=000, ExtOp=1 (branch target into ALUOut). Next by `op`: 000000→EXEC, 100011/101011→MEMADR, 000100→BRANCH, 001101→ORIEX, 000010→JUMP, other→see Configuration.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUop=000 → MEMRD if lw, MEMWR if sw.
- MEMRD: IorD=1 → MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 → FETCH.
- MEMWR: IorD=1, MemWrite=1 → FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=111 → ALUWB. ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=001, PCSource=01, PCWriteCond=1 → FETCH.
- ORIEX: ALUSrcA=1, ALUSrcB=10, ExtOp=0, ALUop=010 → ORIWB. ORIWB: RegDst=0, MemtoReg=0, RegWrite=1 → FETCH.
- JUMP: PCSource=10, PCWrite=1 → FETCH.
- Every signal not listed for a state is 0 in that state.
- `instr_done`=1 in MEMWB, MEMWR, ALUWB, BRANCH, ORIWB, JUMP.

## Timing
- Outputs are combinational decodes of the state register only (Moore); `op`/`zero` affect next state / `PCEn` only.
- Cycles per instruction: lw 5; sw, R-type, ori 4; beq, j 3.
- While `reset`=1: state register loads FETCH on each edge; all write enables (PCWrite, PCWriteCond, PCEn, MemWrite, IRWrite, RegWrite) and `instr_done` forced 0; `illegal` cleared. First fetch occurs in the first cycle after `reset` deasserts.
- Reset asserted mid-instruction: abandons it at the next edge; no partial write-back after that edge.
- `op` must be stable from DECODE until the instruction's last cycle (IR not loaded outside FETCH).
- Unused state codes 13–15 → FETCH on next edge.

## Configuration
- `ILLEGAL_TRAP_EN` defined: unlisted opcode in DECODE → TRAP; TRAP drives all enables 0, holds until reset; `illegal`=1 while in TRAP.
- Not defined: unlisted opcode in DECODE → FETCH (2-cycle NOP, `instr_done` not pulsed); TRAP unreachable; `illegal` tied 0.

## Test plan
- Reset held 3 cycles, release, `op`=001101 → states 0,1,9,10,0; RegWrite=1 only in ORIWB with RegDst=0, ExtOp=0, ALUop=010 in ORIEX.
- `op`=100011 then 101011 → lw states 0,1,2,3,4 (MemtoReg=1, RegWrite=1 in 4); sw states 0,1,2,5 with MemWrite=1 only in 5; `instr_done` pulses once per instruction.
- `op`=000100 with `zero`=1 → PCEn=1 in BRANCH, PCSource=01; repeat with `zero`=0 → PCEn=0 in BRANCH.
- `op`=000010 → states 0,1,11,0; PCWrite=1, PCSource=10 in JUMP; `op`=000000 → EXEC with ALUop=111, ALUWB RegDst=1.
- `op`=111111: with `ILLEGAL_TRAP_EN` → state 12, `illegal`=1, all enables 0 for 10 cycles until reset; without → back to FETCH after DECODE, `illegal`=0.
- Assert `reset` in MEMRD of lw → next state FETCH, RegWrite never asserted for that lw.
